// File: rtl/i2c_slave_fsm.sv
// -----------------------------------------------------------------------------
// i2c_slave_fsm
//   I2C target FSM. Oversamples SCL/SDA on the fast internal clock, detects
//   START / repeated START / STOP, matches a fixed 7-bit address, ACKs it and
//   then receives (master write) or transmits (master read) bytes. SCL is never
//   stretched.
//
// Ports
//   i_clk       internal clock, at least 10x the SCL rate
//   i_rst       synchronous active-high reset
//   i_scl       SCL pin (asynchronous)
//   i_sda       SDA pin (asynchronous)
//   o_sda       SDA open-drain drive: 0 = pull low, 1 = release
//   i_tx_data   byte to transmit, loaded on the SCL fall that starts a byte
//   o_tx_req    1-cycle pulse: next byte must be on i_tx_data within 2 cycles
//   o_rx_data   last byte received from the master
//   o_rx_valid  1-cycle pulse when o_rx_data updates
//   o_rw        R/W bit of the current transaction (1 = master read)
//   o_active    high from address match until STOP, NACK or START
// -----------------------------------------------------------------------------
module i2c_slave_fsm #(
   parameter logic [6:0] P_ADDR = 7'h50
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_req,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rw,
   output logic       o_active
);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StRx,
      StRxAck,
      StTx,
      StTxAck,
      StWaitStop
   } state_e;

   // Pin conditioning: two synchroniser flops plus one history flop per pin.
   logic scl_s1_q, scl_s2_q, scl_d1_q;
   logic sda_s1_q, sda_s2_q, sda_d1_q;

   state_e     state_q;
   logic [7:0] shift_q;
   logic [2:0] bitcnt_q;
   // In the ACK states: 0 = waiting for the first event, 1 = second phase.
   logic       ack_phase_q;

   logic       sda_q;
   logic       tx_req_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;
   logic       rw_q;
   logic       active_q;

   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] shift_in;

   // START/STOP only need SCL high in the current sample, so an SDA edge that
   // lands in the same cycle as an SCL rise is still seen as a bus condition.
   always_comb begin
      scl_rise  = scl_s2_q & ~scl_d1_q;
      scl_fall  = ~scl_s2_q & scl_d1_q;
      start_det = sda_d1_q & ~sda_s2_q & scl_s2_q;
      stop_det  = ~sda_d1_q & sda_s2_q & scl_s2_q;
      shift_in  = {shift_q[6:0], sda_s2_q};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scl_s1_q    <= 1'b1;
         scl_s2_q    <= 1'b1;
         scl_d1_q    <= 1'b1;
         sda_s1_q    <= 1'b1;
         sda_s2_q    <= 1'b1;
         sda_d1_q    <= 1'b1;
         state_q     <= StIdle;
         shift_q     <= 8'h00;
         bitcnt_q    <= 3'd0;
         ack_phase_q <= 1'b0;
         sda_q       <= 1'b1;
         tx_req_q    <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rw_q        <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         scl_s1_q <= i_scl;
         scl_s2_q <= scl_s1_q;
         scl_d1_q <= scl_s2_q;
         sda_s1_q <= i_sda;
         sda_s2_q <= sda_s1_q;
         sda_d1_q <= sda_s2_q;

         tx_req_q   <= 1'b0;
         rx_valid_q <= 1'b0;

         if (start_det) begin
            state_q  <= StAddr;
            bitcnt_q <= 3'd0;
            sda_q    <= 1'b1;
            active_q <= 1'b0;
         end else if (stop_det) begin
            state_q  <= StIdle;
            sda_q    <= 1'b1;
            active_q <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  sda_q <= 1'b1;
               end

               StAddr: begin
                  if (scl_rise) begin
                     shift_q  <= shift_in;
                     bitcnt_q <= bitcnt_q + 3'd1;
                     if (bitcnt_q == 3'd7) begin
                        // shift_in[7:1] is the address, shift_in[0] the R/W bit
                        if (shift_q[6:0] == P_ADDR) begin
                           rw_q        <= sda_s2_q;
                           active_q    <= 1'b1;
                           tx_req_q    <= sda_s2_q;
                           ack_phase_q <= 1'b0;
                           state_q     <= StAddrAck;
                        end else begin
                           state_q <= StWaitStop;
                        end
                     end
                  end
               end

               StAddrAck: begin
                  if (scl_fall) begin
                     if (!ack_phase_q) begin
                        sda_q       <= 1'b0;
                        ack_phase_q <= 1'b1;
                     end else begin
                        bitcnt_q <= 3'd0;
                        if (rw_q) begin
                           shift_q <= i_tx_data;
                           sda_q   <= i_tx_data[7];
                           state_q <= StTx;
                        end else begin
                           sda_q   <= 1'b1;
                           state_q <= StRx;
                        end
                     end
                  end
               end

               StRx: begin
                  if (scl_rise) begin
                     shift_q  <= shift_in;
                     bitcnt_q <= bitcnt_q + 3'd1;
                     if (bitcnt_q == 3'd7) begin
                        rx_data_q   <= shift_in;
                        rx_valid_q  <= 1'b1;
                        ack_phase_q <= 1'b0;
                        state_q     <= StRxAck;
                     end
                  end
               end

               StRxAck: begin
                  if (scl_fall) begin
                     if (!ack_phase_q) begin
                        sda_q       <= 1'b0;
                        ack_phase_q <= 1'b1;
                     end else begin
                        sda_q    <= 1'b1;
                        bitcnt_q <= 3'd0;
                        state_q  <= StRx;
                     end
                  end
               end

               StTx: begin
                  // bitcnt_q counts bits already put on the bus for this byte.
                  if (scl_fall) begin
                     if (bitcnt_q == 3'd7) begin
                        sda_q       <= 1'b1;
                        bitcnt_q    <= 3'd0;
                        ack_phase_q <= 1'b0;
                        state_q     <= StTxAck;
                     end else begin
                        shift_q  <= {shift_q[6:0], 1'b0};
                        sda_q    <= shift_q[6];
                        bitcnt_q <= bitcnt_q + 3'd1;
                     end
                  end
               end

               StTxAck: begin
                  if (scl_rise && !ack_phase_q) begin
                     if (!sda_s2_q) begin
                        tx_req_q    <= 1'b1;
                        ack_phase_q <= 1'b1;
                     end else begin
                        sda_q    <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= StWaitStop;
                     end
                  end else if (scl_fall && ack_phase_q) begin
                     shift_q  <= i_tx_data;
                     sda_q    <= i_tx_data[7];
                     bitcnt_q <= 3'd0;
                     state_q  <= StTx;
                  end
               end

               StWaitStop: begin
                  sda_q <= 1'b1;
               end

               default: begin
                  sda_q   <= 1'b1;
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign o_sda      = sda_q;
   assign o_tx_req   = tx_req_q;
   assign o_rx_data  = rx_data_q;
   assign o_rx_valid = rx_valid_q;
   assign o_rw       = rw_q;
   assign o_active   = active_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_fsm
//   Bus-level master model drives SCL/SDA (wired-AND with the target's drive);
//   expectations come from I2C transaction rules: a target at 0x50 ACKs its
//   address and every written byte, returns the user bytes on reads, and
//   leaves the bus released otherwise.
// -----------------------------------------------------------------------------
module tb_i2c_slave_fsm;

   localparam int Q = 5;  // clocks per quarter SCL period

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       bus_sda;
   logic       dut_sda;
   logic [7:0] tx_data = 8'h00;
   logic       tx_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rw;
   logic       active;

   int checks = 0;
   int errors = 0;

   logic [7:0] rx_q[$];
   logic [7:0] tx_src[$];
   int         tx_req_cnt = 0;
   int         low_cnt = 0;
   int         viol = 0;
   logic       prev_sda = 1'b1;

   assign bus_sda = m_sda & dut_sda;

   always #5 clk = ~clk;

   i2c_slave_fsm #(.P_ADDR(7'h50)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_scl      (scl),
      .i_sda      (bus_sda),
      .o_sda      (dut_sda),
      .i_tx_data  (tx_data),
      .o_tx_req   (tx_req),
      .o_rx_data  (rx_data),
      .o_rx_valid (rx_valid),
      .o_rw       (rw),
      .o_active   (active)
   );

   // User side and bus observers.
   initial forever begin
      @(negedge clk);
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_req) begin
         tx_req_cnt++;
         if (tx_src.size() > 0) tx_data = tx_src.pop_front();
         else tx_data = 8'hFF;
      end
      if (dut_sda === 1'b0) low_cnt++;
      if (scl && prev_sda === 1'b1 && dut_sda === 1'b0) viol++;
      prev_sda = dut_sda;
   end

   task automatic wq();
      repeat (Q) @(posedge clk);
   endtask

   task automatic m_start();
      m_sda = 1'b1; wq();
      scl = 1'b1;   wq();
      m_sda = 1'b0; wq();
      scl = 1'b0;   wq();
   endtask

   task automatic m_stop();
      m_sda = 1'b0; wq();
      scl = 1'b1;   wq();
      m_sda = 1'b1; wq();
   endtask

   task automatic m_bit(input logic b, output logic r);
      m_sda = b; wq();
      scl = 1'b1; wq();
      @(negedge clk);
      r = bus_sda;
      wq();
      scl = 1'b0; wq();
   endtask

   task automatic m_write(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) m_bit(b[i], r);
      m_bit(1'b1, ack);
   endtask

   task automatic m_read(input logic nack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, r);
         b[i] = r;
      end
      m_bit(nack, r);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (dut_sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", dut_sda); end
      checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req got %b want 0", tx_req); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      checks++; if (rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", rw); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
      @(negedge clk);
      rst = 1'b0;
      wq();
   endtask

   task automatic test_write(input int nrand);
      logic [7:0] exp[$];
      logic       ack;
      exp = '{8'h3C, 8'hC3};
      for (int i = 0; i < nrand; i++) exp.push_back(8'($urandom));
      rx_q.delete();
      m_start();
      m_write(8'hA0, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b want 0", ack); end
      checks++; if (rw !== 1'b0) begin errors++; $display("FAIL wr_rw got %b want 0", rw); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL wr_active got %b want 1", active); end
      foreach (exp[i]) begin
         m_write(exp[i], ack);
         checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack[%0d] got %b want 0", i, ack); end
      end
      m_stop();
      checks++;
      if (rx_q.size() != exp.size()) begin
         errors++; $display("FAIL wr_rx_count got %0d want %0d", rx_q.size(), exp.size());
      end else begin
         foreach (exp[i]) begin
            checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL wr_rx_byte[%0d] got %h want %h", i, rx_q[i], exp[i]); end
         end
      end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL wr_active_stop got %b want 0", active); end
   endtask

   task automatic test_read(input int nrand);
      logic [7:0] exp[$];
      logic [7:0] got;
      logic       ack;
      exp = '{8'h96, 8'h5A};
      for (int i = 0; i < nrand; i++) exp.insert(1, 8'($urandom));
      tx_src = exp;
      tx_req_cnt = 0;
      m_start();
      m_write(8'hA1, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b want 0", ack); end
      checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rd_rw got %b want 1", rw); end
      foreach (exp[i]) begin
         m_read(i == exp.size() - 1, got);
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL rd_byte[%0d] got %h want %h", i, got, exp[i]); end
      end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL rd_active_nack got %b want 0", active); end
      checks++; if (dut_sda !== 1'b1) begin errors++; $display("FAIL rd_sda_nack got %b want 1", dut_sda); end
      checks++; if (tx_req_cnt != exp.size()) begin errors++; $display("FAIL rd_tx_req_count got %0d want %0d", tx_req_cnt, exp.size()); end
      m_stop();
   endtask

   task automatic test_mismatch();
      logic ack;
      rx_q.delete();
      low_cnt = 0;
      m_start();
      m_write(8'hA4, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_addr_ack got %b want 1", ack); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL mm_active got %b want 0", active); end
      m_write(8'hFF, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_data_ack got %b want 1", ack); end
      m_stop();
      checks++; if (low_cnt != 0) begin errors++; $display("FAIL mm_sda_low_cycles got %0d want 0", low_cnt); end
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL mm_rx_count got %0d want 0", rx_q.size()); end
   endtask

   task automatic test_repeated_start();
      logic       ack;
      logic [7:0] got;
      rx_q.delete();
      tx_src = '{8'h77};
      m_start();
      m_write(8'hA0, ack);
      m_write(8'h10, ack);
      checks++; if (rw !== 1'b0) begin errors++; $display("FAIL rs_rw_write got %b want 0", rw); end
      m_start();
      m_write(8'hA1, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got %b want 0", ack); end
      checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rs_rw_read got %b want 1", rw); end
      m_read(1'b1, got);
      checks++; if (got !== 8'h77) begin errors++; $display("FAIL rs_read_byte got %h want 77", got); end
      m_stop();
      checks++; if (rx_data !== 8'h10) begin errors++; $display("FAIL rs_rx_data got %h want 10", rx_data); end
      checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL rs_rx_count got %0d want 1", rx_q.size()); end
   endtask

   task automatic test_reset_mid();
      logic       r;
      logic       ack;
      logic [7:0] a;
      a = 8'hA0;
      m_start();
      for (int i = 7; i >= 0; i--) m_bit(a[i], r);
      m_sda = 1'b1;
      wq();
      @(negedge clk);
      checks++; if (dut_sda !== 1'b0) begin errors++; $display("FAIL rm_ack_low got %b want 0", dut_sda); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (dut_sda !== 1'b1) begin errors++; $display("FAIL rm_sda_release got %b want 1", dut_sda); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL rm_active got %b want 0", active); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data got %h want 00", rx_data); end
      checks++; if (rw !== 1'b0) begin errors++; $display("FAIL rm_rw got %b want 0", rw); end
      @(negedge clk);
      rst = 1'b0;
      scl = 1'b1;
      wq(); wq();
      rx_q.delete();
      m_start();
      m_write(8'hA0, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_addr_ack got %b want 0", ack); end
      m_write(8'h01, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_data_ack got %b want 0", ack); end
      m_stop();
      checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h01) begin errors++; $display("FAIL rm_rx got n=%0d data=%h want n=1 data=01", rx_q.size(), rx_data); end
   endtask

   task automatic test_priority();
      logic ack;
      logic r;
      rx_q.delete();
      m_start();
      m_write(8'hA0, ack);
      for (int i = 0; i < 3; i++) m_bit(1'($urandom), r);
      m_sda = 1'b0;
      wq();
      // SCL rise and SDA rise hit the pins together: a STOP with a sample edge.
      scl = 1'b1;
      m_sda = 1'b1;
      wq(); wq();
      @(negedge clk);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL pr_active got %b want 0", active); end
      checks++; if (dut_sda !== 1'b1) begin errors++; $display("FAIL pr_sda got %b want 1", dut_sda); end
      scl = 1'b0;
      wq();
      for (int i = 0; i < 6; i++) m_bit(1'($urandom), r);
      m_stop();
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL pr_rx_count got %0d want 0", rx_q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [6:0] addr;
      logic       rdn;
      logic       match;
      logic       ack;
      logic [7:0] got;
      logic [7:0] data[$];
      int         n;
      for (int t = 0; t < 8; t++) begin
         if ($urandom_range(0, 2) == 0) begin
            addr = 7'($urandom_range(0, 127));
            if (addr == 7'h50) addr = 7'h51;
         end else begin
            addr = 7'h50;
         end
         rdn   = 1'($urandom);
         match = (addr == 7'h50);
         n     = $urandom_range(1, 3);
         data.delete();
         for (int i = 0; i < n; i++) data.push_back(8'($urandom));
         rx_q.delete();
         tx_req_cnt = 0;
         if (match && rdn) tx_src = data;
         m_start();
         m_write({addr, rdn}, ack);
         checks++; if (ack !== !match) begin errors++; $display("FAIL bb_addr_ack[%0d] got %b want %b", t, ack, !match); end
         for (int i = 0; i < n; i++) begin
            if (rdn) begin
               m_read(i == n - 1, got);
               checks++;
               if (got !== (match ? data[i] : 8'hFF)) begin
                  errors++; $display("FAIL bb_read[%0d.%0d] got %h want %h", t, i, got, match ? data[i] : 8'hFF);
               end
            end else begin
               m_write(data[i], ack);
               checks++; if (ack !== !match) begin errors++; $display("FAIL bb_wr_ack[%0d.%0d] got %b want %b", t, i, ack, !match); end
            end
         end
         checks++;
         if (rx_q.size() != ((match && !rdn) ? n : 0)) begin
            errors++; $display("FAIL bb_rx_count[%0d] got %0d want %0d", t, rx_q.size(), (match && !rdn) ? n : 0);
         end else if (match && !rdn) begin
            foreach (data[i]) begin
               checks++; if (rx_q[i] !== data[i]) begin errors++; $display("FAIL bb_rx_byte[%0d.%0d] got %h want %h", t, i, rx_q[i], data[i]); end
            end
         end
         checks++; if (tx_req_cnt != ((match && rdn) ? n : 0)) begin errors++; $display("FAIL bb_tx_req[%0d] got %0d want %0d", t, tx_req_cnt, (match && rdn) ? n : 0); end
         // Randomly chain with a repeated START instead of a STOP.
         if ($urandom_range(0, 1) == 0 || t == 7) m_stop();
      end
   endtask

   initial begin
      test_reset();
      test_write(2);
      test_read(0);
      test_read(2);
      test_mismatch();
      test_repeated_start();
      test_reset_mid();
      test_priority();
      test_back_to_back();
      checks++; if (viol != 0) begin errors++; $display("FAIL sda_low_while_scl_high got %0d want 0", viol); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_fsm.md
Name: i2c_slave_fsm

Overview:
- I2C target (responder) FSM. It is the far end of the bus from the team's I2C master FSM.
- Oversamples the SCL/SDA pins on the fast internal clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs it, then either receives bytes (master write) or transmits bytes (master read).
- Presents a byte-wide data interface to user logic. Does not stretch SCL.

Parameters:
- P_ADDR, 7'h50, 7-bit target address this block responds to.

Ports:
- i_clk  in  1  high-speed internal clock (≥10x SCL rate)
- i_rst  in  1  synchronous, active-high reset
- i_scl  in  1  SCL pin input (asynchronous)
- i_sda  in  1  SDA pin input (asynchronous)
- o_sda  out  1  SDA drive: 0 = pull low, 1 = release (open-drain, pad does the rest)
- i_tx_data  in  8  byte to send on master read; sampled when loaded (see Behaviour)
- o_tx_req  out  1  1-cycle pulse: user must present the next byte on i_tx_data within 2 cycles
- o_rx_data  out  8  last byte received from master
- o_rx_valid  out  1  1-cycle pulse when o_rx_data updates
- o_rw  out  1  R/W bit of the current transaction (1 = master read)
- o_active  out  1  high from address match until STOP/NACK/START

Behaviour:
- Reset (i_rst=1 on a posedge i_clk):
  - Outputs: o_sda=1, o_tx_req=0, o_rx_valid=0, o_rx_data=0, o_rw=0, o_active=0.
  - Internal: state=IDLE; synchroniser flops preset to 1.
  - Reset mid-transfer releases SDA on the next cycle.
- Input conditioning:
  - 2-flop synchroniser per pin, plus one delay flop for edge detect.
  - Pin-to-event latency: 3 cycles.
  - All events below use the synchronised values.
- Bus events:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - SCL rise = sample point; SCL fall = drive point.
- START (from any state, including repeated START): state=ADDR, bitcount=0, o_sda=1, o_active=0.
- STOP (from any state): state=IDLE, o_sda=1, o_active=0.
- If START/STOP and an SCL edge are detected in the same cycle, START/STOP wins.
- States:
  - IDLE:
    - o_sda=1; wait for START.
  - ADDR:
    - Shift SDA in MSB-first on each SCL rise.
    - On the 8th rise, compare shift[7:1] with P_ADDR.
    - Match: latch o_rw=shift[0], set o_active=1. If o_rw=1, pulse o_tx_req the same cycle. Go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP (never drives SDA).
  - ADDR_ACK:
    - On the next SCL fall: o_sda=0. Hold through one SCL rise.
    - On the following SCL fall:
      - Write (o_rw=0): o_sda=1, go to RX.
      - Read (o_rw=1): load shift=i_tx_data, drive o_sda=i_tx_data[7], go to TX.
  - RX:
    - Sample SDA on each SCL rise, MSB first.
    - On the 8th rise: o_rx_data<=byte; o_rx_valid pulses 1 cycle; go to RX_ACK.
  - RX_ACK:
    - On SCL fall: o_sda=0. Always ACK.
    - On the following fall: o_sda=1, bitcount=0, go to RX.
  - TX:
    - On each SCL fall after the first bit, drive the next bit MSB-first.
    - After the 8th bit's SCL fall: o_sda=1, go to TX_ACK.
  - TX_ACK:
    - On SCL rise, sample the master's ACK.
    - SDA=0 (ACK): pulse o_tx_req. On the next fall, load i_tx_data, drive bit 7, go to TX.
    - SDA=1 (NACK): o_sda=1, o_active=0, go to WAIT_STOP.
  - WAIT_STOP:
    - o_sda=1; ignore SCL until STOP (→IDLE) or START (→ADDR).
- Bit counting:
  - bitcount is 3 bits; the 8th bit is detected at bitcount==7, then it wraps to 0.
- o_sda changes only on a detected SCL fall, or on reset/START/STOP release. Never while SCL is high, except the release on START/STOP.

Test Plan:
- Write 2 bytes: START, 0xA0 (addr 0x50, W), 0x3C, 0xC3, STOP → ACK (o_sda=0) in the 9th clock after each byte; o_rx_valid pulses twice with o_rx_data=0x3C then 0xC3; o_rw=0; o_active 1→0 at STOP.
- Read with NACK: START, 0xA1, i_tx_data=0x96 then 0x5A, master ACKs byte 1 and NACKs byte 2 → SDA carries 0x96 then 0x5A MSB-first; o_tx_req pulses 2 times; state WAIT_STOP, SDA released; STOP → IDLE.
- Address mismatch: START, 0xA4 (addr 0x52), 0xFF, STOP → o_sda stays 1 throughout; o_rx_valid never pulses; o_active stays 0.
- Repeated START: write 0xA0, 0x10, then START, 0xA1, read 1 byte (0x77), NACK, STOP → o_rx_data=0x10; o_rw goes 0→1; 0x77 on SDA.
- Reset mid-byte: assert i_rst during an ACK-low phase → o_sda=1 on the next cycle, all outputs at reset values; a following full write of 0xA0, 0x01 works normally.
- START/STOP priority: STOP coinciding with the 4th RX bit → IDLE, no o_rx_valid, o_sda=1.
